// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame decoder.
// Conditions the emulated PS/2 clock/data pair, deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop), and folds the E0/F0 prefixes
// into single make/break key events.
//
// Ports:
//   clk_sys      system clock, all logic on its rising edge
//   reset        asynchronous, active-high reset
//   ps2_clk      PS/2 clock from the I/O bridge (idles high)
//   ps2_data     PS/2 data from the I/O bridge
//   key_strobe   one-cycle pulse: key event valid
//   key_code     scan code with prefixes removed, held until next event
//   key_ext      event was E0-prefixed, held
//   key_pressed  1 = make, 0 = break, held
//   frame_err    one-cycle pulse on start/parity/stop/timeout error
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_pressed,
  output logic       frame_err
);

  localparam logic [3:0]  FiltLast   = 4'(FILTER_LEN - 1);
  localparam logic [19:0] TimeoutVal = 20'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck, StDecode} state_e;

  // Two-flop synchronisers; reset to the idle-high line level.
  logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Glitch filter: the filtered clock follows the synchronised clock only after
  // FILTER_LEN consecutive samples disagree with it.
  logic       filt_clk_q;
  logic [3:0] stab_cnt_q;
  logic       fall;

  // Asserted in the cycle whose edge flips the filtered clock 1->0.
  assign fall = filt_clk_q & ~clk_sync_q & (stab_cnt_q == FiltLast);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      filt_clk_q <= 1'b1;
      stab_cnt_q <= '0;
    end else if (clk_sync_q == filt_clk_q) begin
      stab_cnt_q <= '0;
    end else if (stab_cnt_q == FiltLast) begin
      filt_clk_q <= clk_sync_q;
      stab_cnt_q <= '0;
    end else begin
      stab_cnt_q <= stab_cnt_q + 4'd1;
    end
  end

  // Frame FSM with registered outputs.
  state_e      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic        stop_q;
  logic        ext_pend_q;
  logic        rel_pend_q;
  logic [19:0] timer_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      stop_q      <= 1'b0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      timer_q     <= '0;
      key_strobe  <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_pressed <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fall) begin
            if (!data_sync_q) begin
              state_q   <= StRecv;
              bit_cnt_q <= '0;
              timer_q   <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        StRecv: begin
          if (fall) begin
            timer_q   <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8) begin
              shift_q <= {data_sync_q, shift_q[7:1]};
            end else if (bit_cnt_q == 4'd8) begin
              parity_q <= data_sync_q;
            end else begin
              stop_q  <= data_sync_q;
              state_q <= StCheck;
            end
          end else if (timer_q == TimeoutVal) begin
            // Partial frame is discarded along with any pending prefix.
            frame_err  <= 1'b1;
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
            state_q    <= StIdle;
          end else begin
            timer_q <= timer_q + 20'd1;
          end
        end
        StCheck: begin
          if ((^shift_q ^ parity_q) && stop_q) begin
            state_q <= StDecode;
          end else begin
            frame_err  <= 1'b1;
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StDecode: begin
          state_q <= StIdle;
          case (shift_q)
            8'hE0:   ext_pend_q <= 1'b1;
            8'hF0:   rel_pend_q <= 1'b1;
            8'hE1:   ; // Pause prefix: dropped, pending flags untouched
            default: begin
              key_code    <= shift_q;
              key_ext     <= ext_pend_q;
              key_pressed <= ~rel_pend_q;
              key_strobe  <= 1'b1;
              ext_pend_q  <= 1'b0;
              rel_pend_q  <= 1'b0;
            end
          endcase
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  localparam int unsigned FiltLen = 4;
  localparam int unsigned Tmo     = 300;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_pressed;
  logic       frame_err;

  ps2_key_decoder #(
    .FILTER_LEN(FiltLen),
    .TIMEOUT   (Tmo)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_pressed(key_pressed),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       pressed;
  } ev_t;

  int checks = 0;
  int errors = 0;

  // Observed activity, sampled on the falling edge.
  ev_t obs_q[$];
  int  obs_err  = 0;
  int  obs_both = 0;

  always @(negedge clk_sys) begin
    if (key_strobe) obs_q.push_back({key_code, key_ext, key_pressed});
    if (frame_err) obs_err++;
    if (key_strobe && frame_err) obs_both++;
  end

  // Reference model: pending prefix flags and expectation for the last frame.
  logic m_ext = 1'b0;
  logic m_rel = 1'b0;
  int   exp_n;
  int   exp_err;
  ev_t  exp_ev;

  task automatic model(input logic [7:0] b, input bit valid);
    exp_n   = 0;
    exp_err = 0;
    exp_ev  = '0;
    if (!valid) begin
      exp_err = 1;
      m_ext   = 1'b0;
      m_rel   = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b != 8'hE1) begin
      exp_n  = 1;
      exp_ev = {b, m_ext, ~m_rel};
      m_ext  = 1'b0;
      m_rel  = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(4);
    ps2_clk = 1'b0;
    tick(8);
    ps2_clk = 1'b1;
    tick(4);
  endtask

  task automatic glitches(input int n);
    for (int g = 0; g < n; g++) begin
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(6);
    end
  endtask

  // Sends one frame; glitch_at >= 0 inserts short clock glitches after that data bit.
  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                       input int glitch_at);
    obs_q.delete();
    obs_err = 0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (i == glitch_at) glitches(3);
    end
    send_bit(~(^b) ^ bad_par);
    send_bit(~bad_stop);
    tick(12);
    model(b, !(bad_par || bad_stop));
  endtask

  task automatic test_reset();
    checks++;
    if ({key_strobe, key_code, key_ext, key_pressed, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got strobe=%b code=%h ext=%b pressed=%b err=%b, want all 0",
               key_strobe, key_code, key_ext, key_pressed, frame_err);
    end
  endtask

  // Stop-bit raw fall at edge 0 -> strobe high after edge 2 + FILTER_LEN + 2 only.
  task automatic test_latency();
    logic [7:0] b;
    logic       want;
    b = 8'h1C;
    obs_q.delete();
    obs_err = 0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b));
    ps2_data = 1'b1;
    tick(4);
    ps2_clk = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      want = (k == int'(2 + FiltLen + 2));
      checks++;
      if (key_strobe !== want) begin
        errors++;
        $display("FAIL latency_strobe[k=%0d]: got %b want %b", k, key_strobe, want);
      end
      if (want) begin
        checks++;
        if ({key_code, key_ext, key_pressed} !== {8'h1C, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL latency_event: got code=%h ext=%b pressed=%b want 1c/0/1",
                   key_code, key_ext, key_pressed);
        end
      end
    end
    ps2_clk = 1'b1;
    tick(10);
    checks++;
    if (obs_err != 0 || obs_q.size() != 1) begin
      errors++;
      $display("FAIL latency_count: got err=%0d events=%0d want 0/1", obs_err, obs_q.size());
    end
  endtask

  // Frame table: byte, bad parity, bad stop.
  task automatic run_table(input string name, input logic [9:0] tbl[$]);
    ev_t got;
    foreach (tbl[i]) begin
      frame(tbl[i][9:2], tbl[i][1], tbl[i][0], -1);
      got = (obs_q.size() > 0) ? obs_q[0] : '0;
      checks++;
      if (obs_q.size() != exp_n || obs_err != exp_err || obs_both != 0 ||
          (exp_n == 1 && got !== exp_ev)) begin
        errors++;
        $display("FAIL %s[%0d]: got n=%0d err=%0d ev=%h, want n=%0d err=%0d ev=%h",
                 name, i, obs_q.size(), obs_err, got, exp_n, exp_err, exp_ev);
      end
    end
  endtask

  task automatic test_ext_break();
    run_table("ext_break", '{{8'hE0, 2'b00}, {8'hF0, 2'b00}, {8'h75, 2'b00}, {8'h75, 2'b00}});
  endtask

  task automatic test_parity_err();
    run_table("parity_err", '{{8'hE0, 2'b00}, {8'h1C, 2'b10}, {8'h1C, 2'b00}});
  endtask

  task automatic test_stop_err();
    run_table("stop_err", '{{8'hF0, 2'b00}, {8'h12, 2'b01}, {8'h12, 2'b00}});
  endtask

  task automatic test_pause();
    run_table("pause", '{{8'hE1, 2'b00}, {8'h14, 2'b00}, {8'h77, 2'b00}, {8'hE1, 2'b00},
                         {8'hF0, 2'b00}, {8'h14, 2'b00}, {8'hF0, 2'b00}, {8'h77, 2'b00}});
  endtask

  task automatic test_timeout();
    obs_q.delete();
    obs_err = 0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tick(Tmo + 1 + 20);
    m_ext = 1'b0;
    m_rel = 1'b0;
    checks++;
    if (obs_err != 1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_abort: got err=%0d events=%0d want 1/0", obs_err, obs_q.size());
    end
    run_table("after_timeout", '{{8'h29, 2'b00}});
  endtask

  task automatic test_glitch();
    ev_t got;
    obs_q.delete();
    obs_err = 0;
    for (int g = 0; g < 6; g++) begin
      ps2_data = g[0];
      tick(3);
      glitches(1);
    end
    checks++;
    if (obs_err != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_idle: got err=%0d events=%0d want 0/0", obs_err, obs_q.size());
    end
    frame(8'h3A, 1'b0, 1'b0, 3);
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++;
    if (obs_q.size() != 1 || obs_err != 0 || got !== exp_ev) begin
      errors++;
      $display("FAIL glitch_frame: got n=%0d err=%0d ev=%h want n=1 err=0 ev=%h",
               obs_q.size(), obs_err, got, exp_ev);
    end
  endtask

  task automatic test_reset_mid();
    run_table("pre_reset", '{{8'hE0, 2'b00}, {8'hF0, 2'b00}});
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    reset = 1'b1;
    tick(1);
    checks++;
    if ({key_strobe, key_code, key_ext, key_pressed, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got strobe=%b code=%h ext=%b pressed=%b err=%b",
               key_strobe, key_code, key_ext, key_pressed, frame_err);
    end
    tick(2);
    reset = 1'b0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    tick(4);
    run_table("after_reset", '{{8'h5A, 2'b00}});
  endtask

  task automatic test_random();
    logic [9:0] tbl[$];
    logic [7:0] b;
    int         r;
    for (int n = 0; n < 36; n++) begin
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 2) ? 8'hE1 : 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      tbl.push_back({b, (r == 0) ? 2'b10 : (r == 1) ? 2'b01 : 2'b00});
    end
    run_table("random", tbl);
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    test_reset();
    reset = 1'b0;
    tick(5);
    test_reset();
    test_latency();
    test_ext_break();
    test_parity_err();
    test_stop_err();
    test_pause();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Consumes the emulated PS/2 keyboard stream (ps2_kbd_clk / ps2_kbd_data) that the ARM I/O bridge produces on clk_sys.
- Deserialises 11-bit frames, checks parity and stop bits, and folds the E0/F0 prefixes into single key events.
- Feeds the Specialist keyboard-matrix emulation: one strobe per make or break event.

Parameters:
- FILTER_LEN, 4: consecutive identical clk_sys samples needed before a ps2_clk level change is accepted (range 1..15).
- TIMEOUT, 20000: clk_sys cycles with no accepted ps2_clk falling edge, while mid-frame, before the frame is aborted (range 2..2^20-1).

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock from the I/O bridge; idles high.
- ps2_data  in  1  PS/2 data from the I/O bridge.
- key_strobe  out  1  one-cycle pulse: key event valid.
- key_code  out  8  scan code (prefixes removed); held until the next event.
- key_ext  out  1  event was E0-prefixed; held.
- key_pressed  out  1  1 = make, 0 = break (F0-prefixed); held.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.

Behaviour:
- Reset values: key_strobe=0, key_code=0, key_ext=0, key_pressed=0, frame_err=0. Internally: state=IDLE, bit_cnt=0, shift=0, ext_pend=0, rel_pend=0, filtered clk=1, timer=0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - The synchronised clock feeds a saturating stability counter.
  - The filtered clock changes only after FILTER_LEN consecutive samples differ from its current value.
  - A "fall" event is the single cycle in which the filtered clock goes 1->0. Data is sampled from the synchronised ps2_data in that same cycle.
- Frame FSM:
  - IDLE: on fall, if data=0 (start bit) go to RECV with bit_cnt=0 and timer=0. If data=1, pulse frame_err and stay in IDLE.
  - RECV: each fall stores one bit and increments bit_cnt.
    - bit_cnt 0..7: data bits, LSB first, shifted into shift[7:0].
    - bit_cnt 8: parity bit.
    - bit_cnt 9: stop bit, then go to CHECK.
  - CHECK (one cycle): valid if (^shift ^ parity)==1 (odd parity) and stop==1.
    - Valid: go to DECODE.
    - Invalid: pulse frame_err, clear ext_pend and rel_pend, go to IDLE.
  - DECODE (one cycle), then IDLE:
    - 0xE0: ext_pend<=1, no strobe.
    - 0xF0: rel_pend<=1, no strobe.
    - 0xE1: ignored entirely (no strobe, pending flags unchanged).
    - Any other byte: key_code<=shift, key_ext<=ext_pend, key_pressed<=~rel_pend, key_strobe<=1, then clear ext_pend and rel_pend.
  - Timeout: in RECV, timer increments every cycle without a fall and resets to 0 on each fall. At timer==TIMEOUT: pulse frame_err, clear the pending flags, go to IDLE. The bits already received are discarded.
- Latency: key_strobe goes high exactly 2 cycles after the cycle in which the stop-bit fall is detected (CHECK, then DECODE, then registered output). From a raw ps2_clk edge that is 2 + FILTER_LEN + 2 cycles.
- key_strobe and frame_err are never high in the same cycle. Each is a single-cycle pulse.
- Falls arriving during CHECK/DECODE: not possible at legal PS/2 rates. If one occurs, it is ignored.
- reset mid-frame: all state returns to reset values immediately. The next start bit is decoded normally.
- Pause (E1 14 77 E1 F0 14 F0 77) therefore yields make 0x14, make 0x77, break 0x14, break 0x77. This is accepted behaviour.
- Glitches on ps2_clk shorter than FILTER_LEN cycles generate no fall.

Test Plan:
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1) -> one key_strobe, key_code=0x1C, key_ext=0, key_pressed=1, exactly 2 cycles after the stop-bit fall.
- Sequence E0, F0, 0x75 -> no strobe on the prefixes; a single strobe with key_code=0x75, key_ext=1, key_pressed=0. A following plain 0x75 gives key_ext=0, key_pressed=1.
- Frame 0x1C with parity bit 1 -> frame_err pulse, no strobe. A subsequent valid 0x1C still decodes with key_ext=0.
- F0 then a frame with stop=0 -> frame_err, and rel_pend is cleared. The next valid 0x12 gives key_pressed=1.
- 5 bits sent, then the clock held high for TIMEOUT+1 cycles -> frame_err exactly once. A following valid 0x29 decodes correctly.
- 2-cycle low glitches on ps2_clk with FILTER_LEN=4 -> no bit sampled. reset asserted mid-frame -> outputs return to 0 and the next 0x5A decodes correctly.
